chunk_deserializer: RTL and testbench
=====================================

Name: chunk_deserializer

Overview:
- Receive end of the chunk-serial word stream used in the pipelined-math datapath.
- Accepts one CHUNK-bit slice per beat, least-significant chunk first, and reassembles WIDTH-bit words.
- Presents each completed word on a valid/ready output register.
- Companion to the chunk serializer that feeds the skewed, chunked arithmetic pipelines; honours the shared `en` stall like `shifter`/`unshifter`/`delay`.

Parameters:
- WIDTH, 8, width of the reassembled word in bits.
- CHUNK, 2, bits per input beat. WIDTH % CHUNK must be 0; elaboration fails otherwise.
- NCHUNK = WIDTH/CHUNK is derived (localparam), number of beats per word; counter width is $clog2(NCHUNK), minimum 1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (asserts immediately when low, releases synchronously to clk).
- en  input  1  global pipeline enable; when 0 all state is frozen.
- in_valid  input  1  a chunk is presented on `in`.
- in_first  input  1  qualifies `in` as chunk 0 of a new word.
- in  input  CHUNK  chunk data.
- in_ready  output  1  the deserializer can accept the presented chunk.
- out_valid  output  1  `out` holds a complete word.
- out_ready  input  1  downstream consumes `out` this cycle.
- out  output  WIDTH  reassembled word.

Behaviour:
- Reset (rst=0): cnt=0, partial=0, out=0, out_valid=0, sync_err=0 (when compiled in). in_ready evaluates from reset state, i.e. 1 when en=1.
- Beat accepted: en & in_valid & in_ready on a rising edge.
- Word consumed: en & out_valid & out_ready.
- en=0:
  - in_ready=0; no beat accepted, no word consumed.
  - cnt, partial, out and out_valid hold their values.
- in_ready = en & ((cnt != NCHUNK-1) | ~out_valid | out_ready).
  - Only the final chunk of a word stalls, and only while the output register is occupied and not being drained in the same cycle.
- Chunk placement: accepted chunk with index k is written to partial[k*CHUNK +: CHUNK]. cnt increments by 1 per accepted beat.
- in_first=1 on an accepted beat:
  - The beat is treated as index 0 regardless of cnt; the partial word is discarded.
  - cnt becomes 1, or stays 0 with immediate completion when NCHUNK==1.
- in_first is ignored when the beat is not accepted.
- Completion: when the accepted beat has index NCHUNK-1:
  - out <= {in, partial[(NCHUNK-1)*CHUNK-1:0]}; out_valid <= 1; cnt wraps to 0.
  - Latency: word visible on `out` the cycle after its last chunk is accepted.
- Simultaneous completion and consume: out_valid stays 1 and `out` takes the new word (back-to-back, no bubble).
- Consume without completion: out_valid <= 0; `out` keeps its last value (not cleared).
- Throughput: one chunk per cycle sustained when out_ready=1, giving one word every NCHUNK cycles.
- Reset mid-word: partial word is lost. The first accepted beat after reset is index 0 whether or not in_first is set.
- No combinational path from in_valid/in to out/out_valid. in_ready depends combinationally on en, out_ready and registered state only.

Optional Feature:
- Macro CHUNK_DESERIALIZER_SYNC_CHECK_EN.
- When defined:
  - Extra output port sync_err (1 bit, registered).
  - sync_err pulses high for exactly one cycle after any accepted beat whose in_first disagrees with cnt==0. This covers in_first=1 while cnt!=0 (early restart) and in_first=0 while cnt==0 (missing start marker).
  - Data handling is unchanged by the check: early restart still resyncs, and a missing marker still assembles as index 0.
  - sync_err resets to 0 and holds while en=0.
- When undefined: no sync_err port, no check logic; in_first only resyncs.

Test Plan (WIDTH=8, CHUNK=2, out_ready=1 unless stated):
- Beats 2'b01,2'b10,2'b11,2'b00 with in_first on first -> out=8'h39, out_valid high for 1 cycle, the cycle after the 4th beat.
- Continuous stream of words 8'hA5 then 8'h3C -> out_valid at cycles 5 and 9 after the first beat; no stalls; in_ready constantly 1.
- out_ready=0 holding 8'hA5, next word's 3 chunks accepted, 4th chunk -> in_ready=0 until out_ready=1; then 8'hA5 consumed and the new word loaded in the same cycle.
- Beats 2'b11,2'b11, then in_first with 2'b00,2'b01,2'b10,2'b11 -> out=8'hE4. With SYNC_CHECK_EN, sync_err pulses once on the restart beat.
- en=0 for 3 cycles mid-word with in_valid=1 -> no beats accepted, state frozen, completed word unchanged after en returns.
- rst low after 2 chunks, then a fresh 4 beats for 8'hFF -> out=8'hFF; out_valid=0 throughout reset.

Source files
------------

// File: rtl/chunk_deserializer.sv
// chunk_deserializer: rebuilds WIDTH-bit words from CHUNK-bit beats (least-significant chunk first)
// into a valid/ready output register. Define CHUNK_DESERIALIZER_SYNC_CHECK_EN to add the sync_err flag.
module chunk_deserializer #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic             in_first,
  input  logic [CHUNK-1:0] in,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef CHUNK_DESERIALIZER_SYNC_CHECK_EN
  output logic             sync_err,
`endif
  output logic [WIDTH-1:0] out
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NCHUNK - 1);

  generate
    if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_params
      $error("chunk_deserializer: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  logic [CNT_W-1:0] cnt_r, cnt_n_s, idx_s;
  logic [WIDTH-1:0] partial_r, partial_n_s, asm_s;
  logic [WIDTH-1:0] out_r, out_n_s;
  logic             out_valid_r, out_valid_n_s;
  logic             in_ready_s, accept_s, consume_s, last_s;
`ifdef CHUNK_DESERIALIZER_SYNC_CHECK_EN
  logic             sync_err_r, sync_err_n_s;
`endif

  // State register: counter, partial word, output register and optional framing flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r       <= {CNT_W{1'b0}};
      partial_r   <= {WIDTH{1'b0}};
      out_r       <= {WIDTH{1'b0}};
      out_valid_r <= 1'b0;
`ifdef CHUNK_DESERIALIZER_SYNC_CHECK_EN
      sync_err_r  <= 1'b0;
`endif
    end else begin
      cnt_r       <= cnt_n_s;
      partial_r   <= partial_n_s;
      out_r       <= out_n_s;
      out_valid_r <= out_valid_n_s;
`ifdef CHUNK_DESERIALIZER_SYNC_CHECK_EN
      sync_err_r  <= sync_err_n_s;
`endif
    end
  end

  // Next-state: place the accepted chunk, advance or wrap the counter, load/drain the output.
  always_comb begin
    accept_s  = in_ready_s & in_valid;
    consume_s = en & out_valid_r & out_ready;
    // A start marker forces index 0 and drops whatever was partially assembled.
    idx_s     = in_first ? {CNT_W{1'b0}} : cnt_r;
    asm_s     = in_first ? {WIDTH{1'b0}} : partial_r;
    asm_s[int'(idx_s) * CHUNK +: CHUNK] = in;
    last_s    = (idx_s == LAST_IDX);

    cnt_n_s     = cnt_r;
    partial_n_s = partial_r;
    out_n_s     = out_r;
    if (accept_s) begin
      if (last_s) begin
        cnt_n_s = {CNT_W{1'b0}};
        out_n_s = asm_s;
      end else begin
        cnt_n_s     = idx_s + CNT_W'(1);
        partial_n_s = asm_s;
      end
    end else begin
      cnt_n_s = cnt_r;
    end

    if (accept_s && last_s) begin
      out_valid_n_s = 1'b1;
    end else if (consume_s) begin
      out_valid_n_s = 1'b0;
    end else begin
      out_valid_n_s = out_valid_r;
    end

`ifdef CHUNK_DESERIALIZER_SYNC_CHECK_EN
    if (en) begin
      sync_err_n_s = accept_s & (in_first != (cnt_r == {CNT_W{1'b0}}));
    end else begin
      sync_err_n_s = sync_err_r;
    end
`endif
  end

  // Outputs: only the final chunk can stall, and only behind an undrained output word.
  always_comb begin
    in_ready_s = en & ((cnt_r != LAST_IDX) | ~out_valid_r | out_ready);
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out       = out_r;
`ifdef CHUNK_DESERIALIZER_SYNC_CHECK_EN
  assign sync_err  = sync_err_r;
`endif

endmodule

// File: tb/tb_chunk_deserializer.sv
// tb_chunk_deserializer: directed scenarios plus random traffic against a queue-based word model.
module tb_chunk_deserializer;

  localparam int WIDTH  = 8;
  localparam int CHUNK  = 2;
  localparam int NCHUNK = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_first = 1'b0;
  logic [CHUNK-1:0] in_data = '0;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] dout;
`ifdef CHUNK_DESERIALIZER_SYNC_CHECK_EN
  logic             sync_err;
`endif

  chunk_deserializer #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_first(in_first),
    .in(in_data), .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
`ifdef CHUNK_DESERIALIZER_SYNC_CHECK_EN
    .sync_err(sync_err),
`endif
    .out(dout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: chunks collected for the word in progress, plus the output register.
  logic [CHUNK-1:0] q[$];
  logic [WIDTH-1:0] m_out = '0;
  logic             m_valid = 1'b0;
  logic             m_serr = 1'b0;
  int               serr_pulses = 0;

  // Last values sampled from the DUT by step().
  logic             s_rdy, s_valid;
  logic [WIDTH-1:0] s_out;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, expv, $time);
    end
  endtask

  // One cycle: drive inputs, check at the falling edge, then advance the model at the rising edge.
  task automatic step(input logic e, input logic v, input logic f,
                      input logic [CHUNK-1:0] d, input logic ordy);
    logic exp_rdy, acc, cons;
    logic [WIDTH-1:0] word;
    en = e; in_valid = v; in_first = f; in_data = d; out_ready = ordy;
    @(negedge clk);
    exp_rdy = e & ((q.size() != NCHUNK - 1) | ~m_valid | ordy);
    s_rdy = in_ready; s_valid = out_valid; s_out = dout;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out", 32'(dout), 32'(m_out));
`ifdef CHUNK_DESERIALIZER_SYNC_CHECK_EN
    chk("sync_err", 32'(sync_err), 32'(m_serr));
    if (sync_err === 1'b1) serr_pulses++;
`endif
    @(posedge clk);
    acc  = e & v & exp_rdy;
    cons = e & m_valid & ordy;
    if (e) m_serr = acc && (f != (q.size() == 0));
    if (acc) begin
      if (f) q.delete();
      q.push_back(d);
      if (q.size() == NCHUNK) begin
        word = '0;
        foreach (q[i]) word = word | (WIDTH'(q[i]) << (CHUNK * i));
        m_out = word;
        m_valid = 1'b1;
        q.delete();
      end else if (cons) begin
        m_valid = 1'b0;
      end
    end else if (cons) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w, input logic first, input logic ordy);
    for (int k = 0; k < NCHUNK; k++)
      step(1'b1, 1'b1, (k == 0) ? first : 1'b0, w[k*CHUNK +: CHUNK], ordy);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, 1'b0, '0, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b0; en = 1'b1; in_valid = 1'b0;
    q.delete(); m_valid = 1'b0; m_out = '0; m_serr = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk("rst_hold_valid", 32'(out_valid), 32'd0);
      chk("rst_hold_out", 32'(dout), 32'd0);
    end
    rst = 1'b1;
  endtask

  initial begin
    @(posedge clk); #1;
    do_reset();

    // Basic word, then read it on the following cycle.
    send_word(8'h39, 1'b1, 1'b1);
    idle(1);
    chk("t1_out", 32'(s_out), 32'h39);
    chk("t1_valid", 32'(s_valid), 32'd1);
    idle(1);
    chk("t1_drained", 32'(s_valid), 32'd0);

    // Back-to-back words with no bubbles.
    send_word(8'hA5, 1'b1, 1'b1);
    send_word(8'h3C, 1'b1, 1'b1);
    chk("t2_first_word", 32'(s_out), 32'hA5);
    chk("t2_ready", 32'(s_rdy), 32'd1);
    idle(1);
    chk("t2_second_word", 32'(s_out), 32'h3C);
    idle(2);

    // Backpressure on the final chunk.
    send_word(8'hA5, 1'b1, 1'b0);
    for (int k = 0; k < NCHUNK - 1; k++) step(1'b1, 1'b1, k == 0, 8'h3C >> (CHUNK * k), 1'b0);
    step(1'b1, 1'b1, 1'b0, 2'b00, 1'b0);
    chk("t3_stall", 32'(s_rdy), 32'd0);
    step(1'b1, 1'b1, 1'b0, 2'b00, 1'b0);
    chk("t3_stall_held", 32'(s_out), 32'hA5);
    step(1'b1, 1'b1, 1'b0, 2'b00, 1'b1);
    chk("t3_release", 32'(s_rdy), 32'd1);
    idle(1);
    chk("t3_new_word", 32'(s_out), 32'h3C);
    chk("t3_new_valid", 32'(s_valid), 32'd1);
    idle(1);

    // Early restart.
    serr_pulses = 0;
    step(1'b1, 1'b1, 1'b1, 2'b11, 1'b1);
    step(1'b1, 1'b1, 1'b0, 2'b11, 1'b1);
    send_word(8'hE4, 1'b1, 1'b1);
    idle(1);
    chk("t4_out", 32'(s_out), 32'hE4);
    idle(1);
`ifdef CHUNK_DESERIALIZER_SYNC_CHECK_EN
    chk("t4_serr_pulses", 32'(serr_pulses), 32'd1);
`endif

    // Stall with en=0 mid-word while a completed word waits.
    send_word(8'hA5, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 2'b10, 1'b0);
    step(1'b1, 1'b1, 1'b0, 2'b01, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 1'b0, 2'b11, 1'b1);
      chk("t5_frozen_ready", 32'(s_rdy), 32'd0);
    end
    step(1'b1, 1'b1, 1'b0, 2'b11, 1'b1);
    chk("t5_word_kept", 32'(s_out), 32'hA5);
    step(1'b1, 1'b1, 1'b0, 2'b00, 1'b1);
    idle(1);
    chk("t5_out", 32'(s_out), 32'h36);
    idle(1);

    // Reset mid-word, then a word without a start marker.
    step(1'b1, 1'b1, 1'b1, 2'b01, 1'b1);
    step(1'b1, 1'b1, 1'b0, 2'b01, 1'b1);
    do_reset();
    send_word(8'hFF, 1'b0, 1'b1);
    idle(1);
    chk("t6_out", 32'(s_out), 32'hFF);
    chk("t6_valid", 32'(s_valid), 32'd1);

    // Random traffic.
    for (int n = 0; n < 600; n++)
      step($urandom_range(9, 0) != 0, $urandom_range(3, 0) != 0,
           $urandom_range(9, 0) == 0, CHUNK'($urandom), $urandom_range(9, 0) < 7);
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
